voice_cmd_decoder: RTL

Frame-rate consumer of the signal analyser's `pitch`/`vol` outputs. Once per 60 Hz game frame it samples the two voice features, debounces them, and converts them into character commands: a walk speed and a jump trajectory (vertical offset with rise, fall and cooldown phases). It sits between the audio front end and the game renderer/physics logic.

---
 rtl/voice_pkg.sv | 41 ++++
 rtl/voice_cmd_decoder_debounce.sv | 56 +++++
 rtl/voice_cmd_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// Shared definitions for the voice command path: pitch classes, jump states,
// speed encoding and the small decode helpers used by the top level.
package voice_pkg;

    localparam logic [1:0] PITCH_LOW  = 2'b00;
    localparam logic [1:0] PITCH_MID  = 2'b01;
    localparam logic [1:0] PITCH_HIGH = 2'b11;

    typedef enum logic [1:0] {
        GROUND   = 2'd0,
        RISE     = 2'd1,
        FALL     = 2'd2,
        COOLDOWN = 2'd3
    } jump_state_e;

    localparam logic [1:0] SPEED_STAND = 2'd0;
    localparam logic [1:0] SPEED_SLOW  = 2'd1;
    localparam logic [1:0] SPEED_MID   = 2'd2;
    localparam logic [1:0] SPEED_FAST  = 2'd3;

    // The analyser's unused code 10 is folded onto the low class.
    function automatic logic [1:0] map_pitch(input logic [1:0] p);
        return (p == 2'b10) ? PITCH_LOW : p;
    endfunction

    function automatic logic [1:0] speed_of(input logic v, input logic [1:0] p);
        logic [1:0] s;
        if (!v) begin
            s = SPEED_STAND;
        end else begin
            case (p)
                PITCH_LOW:  s = SPEED_SLOW;
                PITCH_MID:  s = SPEED_MID;
                PITCH_HIGH: s = SPEED_FAST;
                default:    s = SPEED_SLOW;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/voice_cmd_decoder_debounce.sv
// Run-length debouncer: the output only moves once HOLD_FRAMES identical
// samples in a row have been seen.
module voice_debounce #(
    parameter int W           = 1,
    parameter int HOLD_FRAMES = 3
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    localparam int            RW      = $clog2(HOLD_FRAMES + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(HOLD_FRAMES);

    logic [W-1:0]  cand_q, cand_d;
    logic [W-1:0]  q_q, q_d;
    logic [RW-1:0] run_q, run_d;

    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        q_d    = q_q;
        if (d == cand_q) begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + 1'b1;
            end else begin
                run_d = run_q;
            end
        end else begin
            cand_d = d;
            run_d  = RW'(1);
        end
        // Committing on the next-run value lets HOLD_FRAMES = 1 act as a plain register.
        if (run_d == RUN_MAX) begin
            q_d = cand_d;
        end else begin
            q_d = q_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cand_q <= '0;
            run_q  <= '0;
            q_q    <= '0;
        end else begin
            cand_q <= cand_d;
            run_q  <= run_d;
            q_q    <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/voice_cmd_decoder.sv
// Frame-rate voice command decoder: debounced pitch/volume drive walk speed
// and a fixed-step jump trajectory with a post-landing cooldown.
module voice_cmd_decoder
    import voice_pkg::*;
#(
    parameter int HOLD_FRAMES     = 3,
    parameter int JUMP_HEIGHT     = 32,
    parameter int JUMP_STEP       = 4,
    parameter int COOLDOWN_FRAMES = 10
) (
    input  logic       clk_60hz,
    input  logic       resetn,
    input  logic [1:0] pitch,
    input  logic       vol,
    output logic [1:0] speed,
    output logic [7:0] y_offset,
    output logic       airborne,
    output logic       land
);

    localparam int            CW      = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);
    localparam logic [8:0]    HEIGHT9 = 9'(JUMP_HEIGHT);
    localparam logic [8:0]    STEP9   = 9'(JUMP_STEP);
    localparam logic [7:0]    HEIGHT8 = 8'(JUMP_HEIGHT);
    localparam logic [7:0]    STEP8   = 8'(JUMP_STEP);
    localparam logic [7:0]    FIRST8  = (JUMP_STEP < JUMP_HEIGHT) ? STEP8 : HEIGHT8;

    logic [1:0]  pitch_m;
    logic [1:0]  p_st;
    logic        v_st;
    logic [8:0]  sum9;

    jump_state_e state_q, state_d;
    logic [7:0]  y_q, y_d;
    logic [1:0]  speed_q, speed_d;
    logic        airborne_q, airborne_d;
    logic        land_q, land_d;
    logic [CW-1:0] cd_q, cd_d;

    assign pitch_m = map_pitch(pitch);

    voice_debounce #(.W(2), .HOLD_FRAMES(HOLD_FRAMES)) u_pitch_db (
        .clk    (clk_60hz),
        .resetn (resetn),
        .d      (pitch_m),
        .q      (p_st)
    );

    voice_debounce #(.W(1), .HOLD_FRAMES(HOLD_FRAMES)) u_vol_db (
        .clk    (clk_60hz),
        .resetn (resetn),
        .d      (vol),
        .q      (v_st)
    );

    // Nine-bit sum so a step past the apex cannot wrap before the clamp.
    assign sum9 = {1'b0, y_q} + STEP9;

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        speed_d = speed_q;
        cd_d    = cd_q;
        land_d  = 1'b0;
        case (state_q)
            GROUND: begin
                if (v_st && (p_st == PITCH_HIGH)) begin
                    state_d = RISE;
                    y_d     = FIRST8;
                    speed_d = SPEED_FAST;
                end else begin
                    y_d     = 8'd0;
                    speed_d = speed_of(v_st, p_st);
                end
            end
            RISE: begin
                if (sum9 >= HEIGHT9) begin
                    y_d     = HEIGHT8;
                    state_d = FALL;
                end else begin
                    y_d     = sum9[7:0];
                end
            end
            FALL: begin
                if (y_q <= STEP8) begin
                    y_d     = 8'd0;
                    state_d = COOLDOWN;
                    land_d  = 1'b1;
                    cd_d    = CD_LOAD;
                end else begin
                    y_d     = y_q - STEP8;
                end
            end
            COOLDOWN: begin
                y_d     = 8'd0;
                speed_d = speed_of(v_st, p_st);
                cd_d    = cd_q - 1'b1;
                if (cd_q == CW'(1)) begin
                    state_d = GROUND;
                end else begin
                    state_d = COOLDOWN;
                end
            end
            default: begin
                state_d = GROUND;
                y_d     = 8'd0;
                speed_d = SPEED_STAND;
            end
        endcase
        airborne_d = (state_d == RISE) || (state_d == FALL);
    end

    always_ff @(posedge clk_60hz) begin
        if (!resetn) begin
            state_q    <= GROUND;
            y_q        <= 8'd0;
            speed_q    <= SPEED_STAND;
            airborne_q <= 1'b0;
            land_q     <= 1'b0;
            cd_q       <= '0;
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            speed_q    <= speed_d;
            airborne_q <= airborne_d;
            land_q     <= land_d;
            cd_q       <= cd_d;
        end
    end

    assign speed    = speed_q;
    assign y_offset = y_q;
    assign airborne = airborne_q;
    assign land     = land_q;

endmodule
